// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared types and constants for the 2-input gate sweep controller.
package gate_sweep_pkg;

  localparam int NUM_VECTORS = 4;
  localparam int VEC_W       = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Signal bundle between the sweep controller and the host / gate under test.
interface gate_sweep_ctrl_if;
  import gate_sweep_pkg::*;

  logic                   start;
  logic [NUM_VECTORS-1:0] expected;
  logic                   f;
  logic                   a;
  logic                   b;
  logic [VEC_W-1:0]       vec_idx;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [NUM_VECTORS-1:0] mismatch;

  modport master (
    output start, expected, f,
    input  a, b, vec_idx, busy, done, pass, mismatch
  );

  modport slave (
    input  start, expected, f,
    output a, b, vec_idx, busy, done, pass, mismatch
  );

endinterface

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Loadable down-counter that flags expiry once it has counted CYCLES enabled cycles.
module settle_timer #(
  parameter int CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int            W        = $clog2(CYCLES + 1);
  localparam logic [W-1:0]  LOAD_VAL = W'(CYCLES - 1);

  logic [W-1:0] count_q;

  // Loading CYCLES-1 makes the enabled cycle that sees zero the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= LOAD_VAL;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Drives all four input vectors onto a 2-input gate, samples its output after a
// settle time and compares against a latched truth table.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  gate_sweep_ctrl_if.slave  sif
);

  sweep_state_t           state_q, state_d;
  logic [VEC_W-1:0]       vec_q;
  logic [NUM_VECTORS-1:0] exp_q;
  logic [NUM_VECTORS-1:0] mismatch_q;
  logic [NUM_VECTORS-1:0] mismatch_upd;
  logic                   pass_q;
  logic                   accept;
  logic                   last_vec;
  logic                   timer_load;
  logic                   timer_en;
  logic                   timer_expired;

  assign accept     = (state_q == IDLE) && sif.start;
  assign last_vec   = (vec_q == VEC_W'(NUM_VECTORS - 1));
  assign timer_load = accept || ((state_q == SAMPLE) && !last_vec);
  assign timer_en   = (state_q == SETTLE);

  settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sif.start) state_d = SETTLE;
      SETTLE:  if (timer_expired) state_d = SAMPLE;
      SAMPLE:  state_d = last_vec ? DONE : SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The verdict must include the vector being sampled this cycle.
  always_comb begin
    mismatch_upd        = mismatch_q;
    mismatch_upd[vec_q] = (sif.f != exp_q[vec_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q      <= '0;
      exp_q      <= '0;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
    end else if (accept) begin
      vec_q      <= '0;
      exp_q      <= sif.expected;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
    end else if (state_q == SAMPLE) begin
      mismatch_q <= mismatch_upd;
      if (last_vec) begin
        pass_q <= (mismatch_upd == '0);
      end else begin
        vec_q <= vec_q + VEC_W'(1);
      end
    end
  end

  assign sif.a        = vec_q[1];
  assign sif.b        = vec_q[0];
  assign sif.vec_idx  = vec_q;
  assign sif.busy     = (state_q == SETTLE) || (state_q == SAMPLE);
  assign sif.done     = (state_q == DONE);
  assign sif.pass     = pass_q;
  assign sif.mismatch = mismatch_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: random gates and truth tables checked
// against an arithmetic model of the sweep timeline.
module tb_gate_sweep_ctrl;

  localparam int S0   = 2;
  localparam int PER0 = S0 + 1;
  localparam int LAT0 = 4 * PER0;
  localparam int S1   = 1;
  localparam int B2B  = 4 * (S1 + 1) + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   kind0 = 0;
  int   kind1 = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [1:0] ab_log   [20];
  logic [1:0] vec_log  [20];
  logic       busy_log [20];
  int         done_at;
  int         done_cnt;
  logic [3:0] mm_obs, mm_end, mm_k0;
  logic       pass_obs, pass_end, pass_k0;

  always #5 clk = ~clk;

  gate_sweep_ctrl_if if0 ();
  gate_sweep_ctrl_if if1 ();

  gate_sweep_ctrl #(.SETTLE_CYCLES(S0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (if0.slave)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(S1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (if1.slave)
  );

  // Gate kinds: 0 NOR, 1 NAND, 2 XOR, 3 XNOR, 4 AND, 5 OR
  function automatic logic gate_fn(input int kind, input logic a, input logic b);
    case (kind)
      0:       return ~(a | b);
      1:       return ~(a & b);
      2:       return a ^ b;
      3:       return ~(a ^ b);
      4:       return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic [3:0] truth_of(input int kind);
    logic [3:0] t;
    logic [1:0] v;
    for (int i = 0; i < 4; i++) begin
      v    = 2'(i);
      t[i] = gate_fn(kind, v[1], v[0]);
    end
    return t;
  endfunction

  always_comb if0.f = gate_fn(kind0, if0.a, if0.b);
  always_comb if1.f = gate_fn(kind1, if1.a, if1.b);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one sweep on dut0 and records what it observed, cycle by cycle after acceptance.
  task automatic sweep0(input logic [3:0] exp_v, input int kind, input int pulse_at,
                        input logic [3:0] exp_mid);
    kind0        = kind;
    if0.expected = exp_v;
    if0.start    = 1'b1;
    step();
    if0.start    = 1'b0;
    if0.expected = 4'($urandom);
    done_at  = -1;
    done_cnt = 0;
    mm_obs   = 4'bxxxx;
    pass_obs = 1'bx;
    for (int k = 0; k < 20; k++) begin
      ab_log[k]   = {if0.a, if0.b};
      vec_log[k]  = if0.vec_idx;
      busy_log[k] = if0.busy;
      if (k == 0) begin
        mm_k0   = if0.mismatch;
        pass_k0 = if0.pass;
      end
      if (if0.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at  = k;
          mm_obs   = if0.mismatch;
          pass_obs = if0.pass;
        end
      end
      if0.start = (k == pulse_at);
      if (k == pulse_at) if0.expected = exp_mid;
      step();
    end
    if0.start = 1'b0;
    mm_end   = if0.mismatch;
    pass_end = if0.pass;
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    if0.start    = 1'($urandom);
    if0.expected = 4'($urandom);
    if1.start    = 1'($urandom);
    if1.expected = 4'($urandom);
    kind0 = int'($urandom_range(0, 5));
    kind1 = int'($urandom_range(0, 5));
    rst_n = 1'b0;
    step();
    step();
    obs = {if0.a, if0.b, if0.vec_idx, if0.busy, if0.done, if0.pass, if0.mismatch};
    tests_run++;
    if (obs !== 11'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_dut0: got %b expected %b", obs, 11'd0);
    end
    obs = {if1.a, if1.b, if1.vec_idx, if1.busy, if1.done, if1.pass, if1.mismatch};
    tests_run++;
    if (obs !== 11'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_dut1: got %b expected %b", obs, 11'd0);
    end
    if0.start = 1'b0;
    if1.start = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      obs = {if0.a, if0.b, if0.vec_idx, if0.busy, if0.done, if0.pass, if0.mismatch};
      tests_run++;
      if (obs !== 11'd0) begin
        tests_failed++;
        $display("[TB] FAIL idle_after_reset k=%0d: got %b expected %b", k, obs, 11'd0);
      end
    end
  endtask

  task automatic test_pass_sweep();
    logic [1:0] ev;
    sweep0(4'b0001, 0, -1, 4'b0000);
    for (int k = 0; k < 20; k++) begin
      ev = (k < LAT0) ? 2'(k / PER0) : 2'd3;
      tests_run++;
      if (ab_log[k] !== ev || vec_log[k] !== ev) begin
        tests_failed++;
        $display("[TB] FAIL pass_ab k=%0d: got ab=%b vec=%0d expected %b", k, ab_log[k], vec_log[k], ev);
      end
      tests_run++;
      if (busy_log[k] !== (k < LAT0)) begin
        tests_failed++;
        $display("[TB] FAIL pass_busy k=%0d: got %b expected %b", k, busy_log[k], (k < LAT0));
      end
    end
    tests_run++;
    if (done_at !== LAT0 || done_cnt !== 1) begin
      tests_failed++;
      $display("[TB] FAIL pass_done: got at=%0d count=%0d expected at=%0d count=1", done_at, done_cnt, LAT0);
    end
    tests_run++;
    if (pass_obs !== 1'b1 || mm_obs !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL pass_result: got pass=%b mm=%b expected pass=1 mm=0000", pass_obs, mm_obs);
    end
    tests_run++;
    if (pass_end !== 1'b1 || mm_end !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL pass_held: got pass=%b mm=%b expected pass=1 mm=0000", pass_end, mm_end);
    end
  endtask

  task automatic test_fail_sweep();
    sweep0(4'b0011, 0, -1, 4'b0000);
    tests_run++;
    if (pass_k0 !== 1'b0 || mm_k0 !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL fail_clear: got pass=%b mm=%b expected pass=0 mm=0000", pass_k0, mm_k0);
    end
    tests_run++;
    if (done_at !== LAT0) begin
      tests_failed++;
      $display("[TB] FAIL fail_done: got %0d expected %0d", done_at, LAT0);
    end
    tests_run++;
    if (mm_obs !== 4'b0010 || pass_obs !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fail_result: got mm=%b pass=%b expected mm=0010 pass=0", mm_obs, pass_obs);
    end
  endtask

  task automatic test_random_sweeps();
    int         kind;
    int         errs;
    logic [3:0] exp_v, emm;
    logic [1:0] ev;
    for (int n = 0; n < 6; n++) begin
      kind  = int'($urandom_range(0, 5));
      exp_v = ($urandom_range(0, 1) == 1) ? truth_of(kind) : 4'($urandom);
      emm   = truth_of(kind) ^ exp_v;
      sweep0(exp_v, kind, -1, 4'b0000);
      errs = 0;
      for (int k = 0; k < 20; k++) begin
        ev = (k < LAT0) ? 2'(k / PER0) : 2'd3;
        if (ab_log[k] !== ev || busy_log[k] !== (k < LAT0)) errs++;
      end
      tests_run++;
      if (errs !== 0) begin
        tests_failed++;
        $display("[TB] FAIL rand_seq n=%0d: got %0d bad cycles expected 0", n, errs);
      end
      tests_run++;
      if (done_at !== LAT0 || done_cnt !== 1) begin
        tests_failed++;
        $display("[TB] FAIL rand_done n=%0d: got at=%0d count=%0d expected at=%0d count=1", n, done_at, done_cnt, LAT0);
      end
      tests_run++;
      if (mm_obs !== emm || pass_obs !== (emm == 4'b0000) || mm_end !== emm) begin
        tests_failed++;
        $display("[TB] FAIL rand_result n=%0d kind=%0d exp=%b: got mm=%b pass=%b held=%b expected mm=%b pass=%b",
                 n, kind, exp_v, mm_obs, pass_obs, mm_end, emm, (emm == 4'b0000));
      end
      tests_run++;
      if (mm_k0 !== 4'b0000 || pass_k0 !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rand_clear n=%0d: got mm=%b pass=%b expected mm=0000 pass=0", n, mm_k0, pass_k0);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    int late_busy;
    sweep0(4'b0001, 0, PER0 + 1, 4'b1111);
    tests_run++;
    if (done_at !== LAT0 || done_cnt !== 1) begin
      tests_failed++;
      $display("[TB] FAIL ignore_done: got at=%0d count=%0d expected at=%0d count=1", done_at, done_cnt, LAT0);
    end
    tests_run++;
    if (pass_obs !== 1'b1 || mm_obs !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL ignore_result: got pass=%b mm=%b expected pass=1 mm=0000", pass_obs, mm_obs);
    end
    late_busy = 0;
    for (int k = LAT0 + 1; k < 20; k++) if (busy_log[k] !== 1'b0) late_busy++;
    tests_run++;
    if (late_busy !== 0) begin
      tests_failed++;
      $display("[TB] FAIL ignore_restart: got %0d busy cycles after done expected 0", late_busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int          n;
    int          dones;
    logic [10:0] obs;
    kind0        = 0;
    if0.expected = 4'b1110;
    if0.start    = 1'b1;
    step();
    if0.start = 1'b0;
    n = 0;
    while (if0.vec_idx !== 2'd2 && n < 20) begin
      step();
      n++;
    end
    tests_run++;
    if (n >= 20) begin
      tests_failed++;
      $display("[TB] FAIL midrst_reach: got vec=%0d expected 2 within 20 cycles", if0.vec_idx);
    end
    tests_run++;
    if (if0.mismatch !== 4'b0011) begin
      tests_failed++;
      $display("[TB] FAIL midrst_partial: got %b expected 0011", if0.mismatch);
    end
    rst_n = 1'b0;
    #1;
    obs = {if0.a, if0.b, if0.vec_idx, if0.busy, if0.done, if0.pass, if0.mismatch};
    tests_run++;
    if (obs !== 11'd0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_values: got %b expected %b", obs, 11'd0);
    end
    step();
    step();
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 16; k++) begin
      if (if0.done !== 1'b0 || if0.busy !== 1'b0) dones++;
      step();
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_quiet: got %0d active cycles expected 0", dones);
    end
    sweep0(4'b0001, 0, -1, 4'b0000);
    tests_run++;
    if (done_at !== LAT0 || pass_obs !== 1'b1 || mm_obs !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL midrst_resweep: got at=%0d pass=%b mm=%b expected at=%0d pass=1 mm=0000",
               done_at, pass_obs, mm_obs, LAT0);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exps [4];
    logic [3:0] t, emm;
    int         n, r;
    kind1   = int'($urandom_range(0, 5));
    t       = truth_of(kind1);
    exps[0] = t;
    exps[1] = 4'($urandom);
    exps[2] = t ^ 4'b0100;
    exps[3] = t;
    if1.expected = exps[0];
    if1.start    = 1'b1;
    step();
    for (int k = 0; k < 4 * B2B; k++) begin
      n = k / B2B;
      r = k % B2B;
      if (r == 0) if1.expected = (n + 1 < 4) ? exps[n + 1] : 4'($urandom);
      if (r == B2B - 2) begin
        emm = t ^ exps[n];
        tests_run++;
        if (if1.done !== 1'b1 || if1.mismatch !== emm || if1.pass !== (emm == 4'b0000)) begin
          tests_failed++;
          $display("[TB] FAIL b2b_done k=%0d: got done=%b mm=%b pass=%b expected done=1 mm=%b pass=%b",
                   k, if1.done, if1.mismatch, if1.pass, emm, (emm == 4'b0000));
        end
      end else begin
        tests_run++;
        if (if1.done !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL b2b_quiet k=%0d: got done=%b expected 0", k, if1.done);
        end
      end
      step();
    end
    if1.start = 1'b0;
    for (int k = 0; k < B2B + 2; k++) step();
  endtask

  initial begin
    if0.start    = 1'b0;
    if0.expected = 4'b0000;
    if1.start    = 1'b0;
    if1.expected = 4'b0000;
    #2;
    test_reset();
    test_pass_sweep();
    test_fail_sweep();
    test_random_sweeps();
    test_ignored_inputs();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
